iq_mixer_cic: RTL and testbench

//  Downstream consumer of the NCO. Multiplies the 1-bit sampled RF input (+1/-1) by the NCO

---
 rtl/sdr_pkg.sv | 26 ++
 rtl/cic_decimator.sv | 66 ++++++
 rtl/iq_mixer_cic.sv | 115 +++++++++++
 tb/tb_iq_mixer_cic.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_pkg
//  Description : Shared sizing helper and I/Q sample type for the SDR
//                receive chain (mixer, CIC decimators, demod).
//  Revision    : 1.0  initial release
// ============================================================================
package sdr_pkg;

    // Default width of one baseband sample leaving the decimator.
    localparam int c_IQ_WIDTH = 16;

    // CIC register width: input width plus log2(DECIM) growth bits per stage
    // (differential delay fixed at 1).
    function automatic int calc_widthc(input int width, input int stages, input int decim);
        return width + stages * $clog2(decim);
    endfunction

    // One decimated baseband sample pair as handed to the demod chain.
    typedef struct packed {
        logic signed [c_IQ_WIDTH-1:0] i;
        logic signed [c_IQ_WIDTH-1:0] q;
    } iq_sample_t;

endpackage : sdr_pkg
`default_nettype wire

// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : cic_decimator
//  Description : One rail of an N-stage CIC decimator. Integrators run at the
//                input rate, combs run on the shared decimation tick and are
//                pipelined one frame per stage. The output is the top WIDTHO
//                bits of the last comb (truncated, no rounding).
//  Revision    : 1.0  initial release
// ============================================================================
module cic_decimator #(
    parameter int WIDTHC = 46,
    parameter int WIDTHO = 16,
    parameter int STAGES = 5
) (
    input  logic                     clock,
    input  logic                     clock_sreset_n,
    input  logic                     enable,
    input  logic                     tick,
    input  logic signed [WIDTHC-1:0] sample_in,
    output logic signed [WIDTHO-1:0] sample_out
);

    logic signed [WIDTHC-1:0] r_integ [STAGES];
    logic signed [WIDTHC-1:0] r_comb  [STAGES];
    logic signed [WIDTHC-1:0] r_dly   [STAGES];
    logic                     w_unused_lsbs;

    // Integrator cascade; modular wrap-around is relied on, the combs undo it.
    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_integ[k] <= '0;
            end
        end else if (enable) begin
            r_integ[0] <= r_integ[0] + sample_in;
            for (int k = 1; k < STAGES; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    // Comb cascade at the decimated rate; each stage consumes the previous
    // stage's registered output, so the chain is pipelined across frames.
    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_comb[k] <= '0;
                r_dly[k]  <= '0;
            end
        end else if (tick) begin
            r_comb[0] <= r_integ[STAGES-1] - r_dly[0];
            r_dly[0]  <= r_integ[STAGES-1];
            for (int k = 1; k < STAGES; k++) begin
                r_comb[k] <= r_comb[k-1] - r_dly[k];
                r_dly[k]  <= r_comb[k-1];
            end
        end
    end

    // Truncate to the output width; the last comb only changes on a tick, so
    // the output naturally holds between pulses.
    assign sample_out    = r_comb[STAGES-1][WIDTHC-1 -: WIDTHO];
    assign w_unused_lsbs = ^r_comb[STAGES-1][WIDTHC-WIDTHO-1:0];

endmodule : cic_decimator
`default_nettype wire

// File: rtl/iq_mixer_cic.sv
`default_nettype none
// ============================================================================
//  Module      : iq_mixer_cic
//  Description : Mixes a 1-bit RF sample (+1/-1) with NCO cosine/sine into
//                baseband I/Q, then decimates each rail by DECIM with an
//                N-stage CIC. Emits one I/Q pair per DECIM enabled cycles
//                with a one-cycle out_valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module iq_mixer_cic
    import sdr_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 5,
    parameter int DECIM  = 64,
    parameter int WIDTHO = 16
) (
    input  logic                    clock,
    input  logic                    clock_sreset_n,
    input  logic                    enable,
    input  logic                    rf_in,
    input  logic signed [WIDTH-1:0] sine_in,
    input  logic signed [WIDTH-1:0] cosine_in,
    output logic signed [WIDTHO-1:0] i_out,
    output logic signed [WIDTHO-1:0] q_out,
    output logic                    out_valid
);

    localparam int c_WIDTHC = calc_widthc(WIDTH, STAGES, DECIM);
    localparam int c_CNT_W  = $clog2(DECIM);
    localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(DECIM - 1);
    localparam logic signed [WIDTH-1:0] c_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] c_MAX     = {1'b0, {(WIDTH-1){1'b1}}};

    logic signed [WIDTH-1:0]    r_i_mix;
    logic signed [WIDTH-1:0]    r_q_mix;
    logic [c_CNT_W-1:0]         r_cnt;
    logic                       r_out_valid;
    logic                       w_tick;
    logic signed [c_WIDTHC-1:0] w_i_ext;
    logic signed [c_WIDTHC-1:0] w_q_ext;

    // Negation that clamps the most negative code instead of wrapping to itself.
    function automatic logic signed [WIDTH-1:0] f_neg_sat(input logic signed [WIDTH-1:0] x);
        if (x == c_MIN) begin
            return c_MAX;
        end
        return -x;
    endfunction

    // Mixer register: rf_in selects +1 or -1 times the NCO outputs.
    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            r_i_mix <= '0;
            r_q_mix <= '0;
        end else if (enable) begin
            r_i_mix <= rf_in ? cosine_in : f_neg_sat(cosine_in);
            r_q_mix <= rf_in ? f_neg_sat(sine_in) : sine_in;
        end
    end

    assign w_i_ext = {{(c_WIDTHC-WIDTH){r_i_mix[WIDTH-1]}}, r_i_mix};
    assign w_q_ext = {{(c_WIDTHC-WIDTH){r_q_mix[WIDTH-1]}}, r_q_mix};

    // Shared decimation tick on the last enabled cycle of each frame.
    assign w_tick = enable && (r_cnt == c_CNT_LAST);

    // Decimation counter, frozen while enable is low.
    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    // Output strobe lines up with the comb results registered on the tick.
    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_tick;
        end
    end

    assign out_valid = r_out_valid;

    cic_decimator #(
        .WIDTHC (c_WIDTHC),
        .WIDTHO (WIDTHO),
        .STAGES (STAGES)
    ) u_cic_i (
        .clock          (clock),
        .clock_sreset_n (clock_sreset_n),
        .enable         (enable),
        .tick           (w_tick),
        .sample_in      (w_i_ext),
        .sample_out     (i_out)
    );

    cic_decimator #(
        .WIDTHC (c_WIDTHC),
        .WIDTHO (WIDTHO),
        .STAGES (STAGES)
    ) u_cic_q (
        .clock          (clock),
        .clock_sreset_n (clock_sreset_n),
        .enable         (enable),
        .tick           (w_tick),
        .sample_in      (w_q_ext),
        .sample_out     (q_out)
    );

endmodule : iq_mixer_cic
`default_nettype wire

// File: tb/tb_iq_mixer_cic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_mixer_cic
//  Description : Self-checking bench for iq_mixer_cic. A frame-level CIC
//                reference model is compared against the DUT every cycle;
//                directed scenarios pin the model with literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iq_mixer_cic;

    localparam int WIDTH  = 16;
    localparam int STAGES = 5;
    localparam int DECIM  = 64;
    localparam int WIDTHO = 16;
    localparam int WC     = WIDTH + STAGES * $clog2(DECIM);
    localparam int BOUND  = 400;

    logic clock = 1'b0;
    logic clock_sreset_n;
    logic enable;
    logic rf_in;
    logic signed [WIDTH-1:0]  sine_in;
    logic signed [WIDTH-1:0]  cosine_in;
    logic signed [WIDTHO-1:0] i_out;
    logic signed [WIDTHO-1:0] q_out;
    logic out_valid;

    always #5 clock = ~clock;

    iq_mixer_cic #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .DECIM  (DECIM),
        .WIDTHO (WIDTHO)
    ) dut (
        .clock          (clock),
        .clock_sreset_n (clock_sreset_n),
        .enable         (enable),
        .rf_in          (rf_in),
        .sine_in        (sine_in),
        .cosine_in      (cosine_in),
        .i_out          (i_out),
        .q_out          (q_out),
        .out_valid      (out_valid)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Wrap a value to WC-bit two's complement.
    function automatic longint wrap(input longint x);
        longint t;
        t = x <<< (64 - WC);
        return t >>> (64 - WC);
    endfunction

    // Multiply an NCO sample by +1/-1, clamping the one unrepresentable result.
    function automatic longint mix(input bit plus, input longint v);
        longint r;
        r = plus ? v : -v;
        if (r > 32767) r = 32767;
        return r;
    endfunction

    bit     m_ready = 0;
    bit     m_valid = 0;
    int     m_cnt   = 0;
    longint m_mix   [2];
    longint m_acc   [2][STAGES];
    longint m_prev  [2][STAGES];   // previous frame's input to each comb stage
    longint m_cout  [2][STAGES];   // last output of each comb stage
    longint m_exp   [2];

    always @(posedge clock) begin
        cyc++;
        if (!clock_sreset_n) begin
            m_ready = 1;
            m_valid = 0;
            m_cnt   = 0;
            for (int r = 0; r < 2; r++) begin
                m_mix[r] = 0;
                m_exp[r] = 0;
                for (int k = 0; k < STAGES; k++) begin
                    m_acc[r][k] = 0; m_prev[r][k] = 0; m_cout[r][k] = 0;
                end
            end
        end else begin
            m_valid = enable && (m_cnt == DECIM - 1);
            if (m_valid) begin
                for (int r = 0; r < 2; r++) begin
                    longint stage_in [STAGES];
                    stage_in[0] = m_acc[r][STAGES-1];
                    for (int k = 1; k < STAGES; k++) stage_in[k] = m_cout[r][k-1];
                    for (int k = 0; k < STAGES; k++) begin
                        m_cout[r][k] = wrap(stage_in[k] - m_prev[r][k]);
                        m_prev[r][k] = stage_in[k];
                    end
                    m_exp[r] = m_cout[r][STAGES-1] >>> (WC - WIDTHO);
                end
            end
            if (enable) begin
                for (int r = 0; r < 2; r++) begin
                    for (int k = STAGES - 1; k >= 1; k--)
                        m_acc[r][k] = wrap(m_acc[r][k] + m_acc[r][k-1]);
                    m_acc[r][0] = wrap(m_acc[r][0] + m_mix[r]);
                end
                m_mix[0] = mix(rf_in, longint'(cosine_in));
                m_mix[1] = mix(!rf_in, longint'(sine_in));
                m_cnt = (m_cnt + 1) % DECIM;
            end
        end
    end

    // Every-cycle comparison of DUT against model.
    always @(negedge clock) begin
        if (m_ready) begin
            check("out_valid", longint'(out_valid), longint'(m_valid));
            check("i_out", longint'(i_out), m_exp[0]);
            check("q_out", longint'(q_out), m_exp[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait for a pulse (sampled at negedge); returns cycle stamp, or flags timeout.
    task automatic wait_pulse(output int stamp);
        int n;
        n = 0;
        stamp = -1;
        while (n < BOUND) begin
            @(negedge clock);
            n++;
            if (out_valid) begin
                stamp = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL pulse_timeout: got none expected pulse within %0d cycles", BOUND);
    endtask

    task automatic run_pulses(input int n);
        int s;
        for (int i = 0; i < n; i++) wait_pulse(s);
    endtask

    int t0, t1, tr;

    initial begin
        clock_sreset_n = 1'b0;
        enable    = 1'b0;
        rf_in     = 1'b0;
        sine_in   = '0;
        cosine_in = '0;
        step(); step();

        // Release with a constant +cos input.
        clock_sreset_n = 1'b1;
        enable    = 1'b1;
        rf_in     = 1'b1;
        cosine_in = 16'sd16384;
        sine_in   = 16'sd0;
        tr = cyc;
        wait_pulse(t0);
        check("first_pulse_latency", longint'(t0 - tr), 64);
        wait_pulse(t1);
        check("cadence", longint'(t1 - t0), 64);
        run_pulses(10);
        check("step_i_pos", longint'(i_out), 16384);
        check("step_q_zero", longint'(q_out), 0);

        // rf_in = 0 negates the I rail.
        step();
        rf_in = 1'b0;
        run_pulses(12);
        check("step_i_neg", longint'(i_out), -16384);

        // Negating the most negative code saturates.
        step();
        cosine_in = -16'sd32768;
        run_pulses(12);
        check("sat_negate", longint'(i_out), 32767);

        // Alternating rf_in cancels over an even frame.
        step();
        cosine_in = 16'sd16384;
        for (int i = 0; i < 12 * DECIM; i++) begin
            rf_in = ~rf_in;
            step();
        end
        wait_pulse(t0);
        check("toggle_zero_i", longint'(i_out), 0);

        // Enable gap mid-frame stretches the frame by the gap length.
        step();
        rf_in = 1'b1;
        wait_pulse(t0);
        wait_pulse(t1);
        check("cadence_2", longint'(t1 - t0), 64);
        for (int i = 0; i < 20; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();
        enable = 1'b1;
        wait_pulse(t0);
        check("gap_delay", longint'(t0 - t1), 74);
        wait_pulse(t1);
        check("cadence_after_gap", longint'(t1 - t0), 64);

        // One-cycle reset mid-frame clears outputs and restarts the frame.
        run_pulses(8);
        for (int i = 0; i < 30; i++) step();
        clock_sreset_n = 1'b0;
        step();
        clock_sreset_n = 1'b1;
        @(negedge clock);
        tr = cyc;
        check("rst_i", longint'(i_out), 0);
        check("rst_q", longint'(q_out), 0);
        check("rst_valid", longint'(out_valid), 0);
        wait_pulse(t0);
        check("rst_first_pulse", longint'(t0 - tr), 64);

        // Randomised run checked by the model every cycle.
        for (int i = 0; i < 10000; i++) begin
            step();
            enable = ($urandom_range(0, 7) != 0);
            rf_in  = $urandom_range(0, 1) == 1;
            sine_in   = ($urandom_range(0, 15) == 0) ? -16'sd32768 : WIDTH'($urandom);
            cosine_in = ($urandom_range(0, 15) == 0) ? -16'sd32768 : WIDTH'($urandom);
        end
        step();
        enable = 1'b1;
        for (int i = 0; i < 2 * DECIM; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_iq_mixer_cic
`default_nettype wire
